// File: rtl/bz_rom_loader_if.sv
`default_nettype none
// ============================================================================
// bz_rom_loader_if : ioctl download stream and core ROM write port bundle
// Rev 1.0
// ============================================================================
interface bz_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic [1:0]  mem_sel;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;
  logic        game_reset;
  logic        load_done;
  logic        drop_err;
  logic        sum_ok;

  // master: download source plus core side; slave: the loader
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    input  ioctl_wait, mem_req, mem_sel, mem_addr, mem_data,
    input  game_reset, load_done, drop_err, sum_ok
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    output ioctl_wait, mem_req, mem_sel, mem_addr, mem_data,
    output game_reset, load_done, drop_err, sum_ok
  );
endinterface
`default_nettype wire

// File: rtl/bz_rom_loader.sv
`default_nettype none
// ============================================================================
// bz_rom_loader : ioctl ROM image -> BattleZone ROM write port (option: ROM_CHECKSUM_EN)
// Rev 1.0
// ============================================================================
module bz_rom_loader #(
  parameter logic [7:0]  ROM_INDEX    = 8'd0,
  parameter logic [15:0] PROG_SIZE    = 16'h3000,
  parameter logic [15:0] VEC_SIZE     = 16'h1000,
  parameter logic [15:0] MATH_SIZE    = 16'h0400,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] EXPECTED_SUM = 16'h0000
) (
  input  logic           clk_sys,
  input  logic           reset,
  bz_rom_loader_if.slave bus
);

  localparam int c_aw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [24:0]     c_vec_base  = {9'd0, PROG_SIZE};
  localparam logic [24:0]     c_math_base = c_vec_base + {9'd0, VEC_SIZE};
  localparam logic [24:0]     c_img_end   = c_math_base + {9'd0, MATH_SIZE};
  localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);
  localparam logic [c_cw-1:0] c_cnt_one   = c_cw'(1);
  localparam logic [c_cw-1:0] c_cnt_full  = c_cw'(FIFO_DEPTH);
  localparam logic [c_cw-1:0] c_cnt_wait  = c_cw'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] off;
    logic [7:0]  data;
  } entry_t;

  state_t          state_q;
  logic            sel_q;
  entry_t          fifo_mem [FIFO_DEPTH];
  logic [c_aw-1:0] wr_ptr_q, rd_ptr_q;
  logic [c_cw-1:0] count_q, w_count_d;
  logic            wait_q, mem_req_q, game_reset_q, load_done_q, drop_err_q, sum_ok_q;
  logic [1:0]      mem_sel_q;
  logic [15:0]     mem_addr_q;
  logic [7:0]      mem_data_q;
`ifdef ROM_CHECKSUM_EN
  logic [15:0]     checksum_q;
`else
  // EXPECTED_SUM only matters when checksumming is built in
  logic            w_unused_sum;
  assign w_unused_sum = ^EXPECTED_SUM;
`endif

  logic   w_sel, w_wr_load, w_in_range, w_full, w_push, w_pop, w_bad;
  entry_t w_entry;

  assign w_sel     = bus.ioctl_download & (bus.ioctl_index == ROM_INDEX);
  assign w_wr_load = (state_q == S_LOAD) & w_sel & bus.ioctl_wr;
  assign w_full    = (count_q == c_cnt_full);
  assign w_push    = w_wr_load & w_in_range & ~w_full;
  assign w_bad     = w_wr_load & (~w_in_range | w_full);
  // the output register is refilled whenever it is idle or being acknowledged
  assign w_pop     = (count_q != '0) & (~mem_req_q | bus.mem_ack);

  always_comb begin
    w_entry.data = bus.ioctl_dout;
    w_entry.sel  = 2'd0;
    w_entry.off  = bus.ioctl_addr[15:0];
    w_in_range   = 1'b1;
    if (bus.ioctl_addr < c_vec_base) begin
      w_entry.sel = 2'd0;
    end else if (bus.ioctl_addr < c_math_base) begin
      w_entry.sel = 2'd1;
      w_entry.off = 16'(bus.ioctl_addr - c_vec_base);
    end else if (bus.ioctl_addr < c_img_end) begin
      w_entry.sel = 2'd2;
      w_entry.off = 16'(bus.ioctl_addr - c_math_base);
    end else begin
      w_in_range = 1'b0;
    end
  end

  always_comb begin
    w_count_d = count_q;
    if (w_push && !w_pop) begin
      w_count_d = count_q + c_cnt_one;
    end else if (!w_push && w_pop) begin
      w_count_d = count_q - c_cnt_one;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_push) begin
      fifo_mem[wr_ptr_q] <= w_entry;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      sel_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wait_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_sel_q    <= 2'd0;
      mem_addr_q   <= 16'd0;
      mem_data_q   <= 8'd0;
      game_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      drop_err_q   <= 1'b0;
      sum_ok_q     <= 1'b0;
`ifdef ROM_CHECKSUM_EN
      checksum_q   <= 16'd0;
`endif
    end else begin
      sel_q       <= w_sel;
      load_done_q <= 1'b0;
      count_q     <= w_count_d;
      // one slot stays free for a byte already in flight when wait rises
      wait_q      <= (w_count_d >= c_cnt_wait);

      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + c_ptr_one;
      end
      if (w_pop) begin
        rd_ptr_q   <= rd_ptr_q + c_ptr_one;
        mem_sel_q  <= fifo_mem[rd_ptr_q].sel;
        mem_addr_q <= fifo_mem[rd_ptr_q].off;
        mem_data_q <= fifo_mem[rd_ptr_q].data;
        mem_req_q  <= 1'b1;
      end else if (mem_req_q && bus.mem_ack) begin
        mem_req_q  <= 1'b0;
      end

      if (w_bad) begin
        drop_err_q <= 1'b1;
      end
`ifdef ROM_CHECKSUM_EN
      if (w_push) begin
        checksum_q <= checksum_q + {8'd0, bus.ioctl_dout};
      end
`endif

      case (state_q)
        S_IDLE: begin
          if (w_sel && !sel_q) begin
            drop_err_q   <= 1'b0;
            game_reset_q <= 1'b1;
            sum_ok_q     <= 1'b0;
`ifdef ROM_CHECKSUM_EN
            checksum_q   <= 16'd0;
`endif
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (sel_q && !w_sel) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((count_q == '0) && !mem_req_q) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          load_done_q  <= 1'b1;
`ifdef ROM_CHECKSUM_EN
          sum_ok_q     <= (checksum_q == EXPECTED_SUM);
          game_reset_q <= (checksum_q != EXPECTED_SUM);
`else
          sum_ok_q     <= 1'b1;
          game_reset_q <= 1'b0;
`endif
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ioctl_wait = wait_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_sel    = mem_sel_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_data   = mem_data_q;
  assign bus.game_reset = game_reset_q;
  assign bus.load_done  = load_done_q;
  assign bus.drop_err   = drop_err_q;
  assign bus.sum_ok     = sum_ok_q;

endmodule
`default_nettype wire

// File: tb/tb_bz_rom_loader.sv
`default_nettype none
// ============================================================================
// tb_bz_rom_loader : randomized self-checking bench with a region/queue model
// Rev 1.0
// ============================================================================
module tb_bz_rom_loader;
  localparam logic [15:0] EXP_SUM = 16'h00FF;
  localparam int          DEPTH   = 4;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  bz_rom_loader_if bus ();

  bz_rom_loader #(
    .ROM_INDEX(8'd0), .PROG_SIZE(16'h3000), .VEC_SIZE(16'h1000), .MATH_SIZE(16'h0400),
    .FIFO_DEPTH(DEPTH), .EXPECTED_SUM(EXP_SUM)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int          tests = 0;
  int          fails = 0;
  logic [25:0] exp_q[$];
  logic [25:0] obs_q[$];
  logic [15:0] model_sum = 16'd0;
  bit          model_drop = 1'b0;
  int          ack_mode = 1;   // 0: held low, 1: held high, 2: random
  logic        ack_rnd = 1'b0;
  int          stab_viol = 0;
  int          done_cnt = 0;
  logic [25:0] last_word = '0;
  bit          last_pending = 1'b0;

  assign bus.mem_ack = (ack_mode == 1) || ((ack_mode == 2) && ack_rnd);

  always @(posedge clk_sys) begin
    #1;
    ack_rnd = ($urandom_range(0, 1) == 1);
  end

  // Collect every accepted write and note any field change while a request waits
  always @(negedge clk_sys) begin
    if (reset) begin
      last_pending = 1'b0;
    end else begin
      if (bus.load_done) done_cnt++;
      if (bus.mem_req) begin
        if (last_pending && ({bus.mem_sel, bus.mem_addr, bus.mem_data} !== last_word)) stab_viol++;
        if (bus.mem_ack) begin
          obs_q.push_back({bus.mem_sel, bus.mem_addr, bus.mem_data});
          last_pending = 1'b0;
        end else begin
          last_pending = 1'b1;
          last_word = {bus.mem_sel, bus.mem_addr, bus.mem_data};
        end
      end else begin
        last_pending = 1'b0;
      end
    end
  end

  function automatic void model_byte(input logic [24:0] a, input logic [7:0] d);
    if (a < 25'h3000) begin
      exp_q.push_back({2'd0, a[15:0], d});
      model_sum += {8'd0, d};
    end else if (a < 25'h4000) begin
      exp_q.push_back({2'd1, 16'(a - 25'h3000), d});
      model_sum += {8'd0, d};
    end else if (a < 25'h4400) begin
      exp_q.push_back({2'd2, 16'(a - 25'h4000), d});
      model_sum += {8'd0, d};
    end else begin
      model_drop = 1'b1;
    end
  endfunction

  function automatic bit sum_expect();
`ifdef ROM_CHECKSUM_EN
    return model_sum == EXP_SUM;
`else
    return 1'b1;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    int guard = 0;
    while (bus.ioctl_wait && guard < 200) begin
      tick(1);
      guard++;
    end
    if (guard >= 200) begin
      tests++; fails++;
      $display("FAIL wait_timeout: ioctl_wait still %0b after %0d cycles, want 0", bus.ioctl_wait, guard);
    end
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = a; bus.ioctl_dout = d;
    tick(1);
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic start_load(input logic [7:0] idx);
    exp_q.delete(); obs_q.delete();
    model_sum = 16'd0; model_drop = 1'b0;
    bus.ioctl_index = idx; bus.ioctl_download = 1'b1;
    tick(2);
  endtask

  task automatic finish_load(output bit got, output logic gr, output logic sok);
    got = 1'b0; gr = 1'bx; sok = 1'bx;
    bus.ioctl_download = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk_sys);
      if (bus.load_done) begin
        got = 1'b1; gr = bus.game_reset; sok = bus.sum_ok;
      end
    end
    @(posedge clk_sys); #1;
    tick(2);
  endtask

  task automatic test_reset();
    tests++; if (bus.game_reset !== 1'b1) begin fails++; $display("FAIL rst_game_reset got %b want 1", bus.game_reset); end
    tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL rst_mem_req got %b want 0", bus.mem_req); end
    tests++; if (bus.ioctl_wait !== 1'b0) begin fails++; $display("FAIL rst_wait got %b want 0", bus.ioctl_wait); end
    tests++; if (bus.load_done !== 1'b0) begin fails++; $display("FAIL rst_load_done got %b want 0", bus.load_done); end
    tests++; if ({bus.drop_err, bus.sum_ok} !== 2'b00) begin fails++; $display("FAIL rst_flags got %b want 00", {bus.drop_err, bus.sum_ok}); end
    tests++; if ({bus.mem_sel, bus.mem_addr, bus.mem_data} !== 26'd0) begin
      fails++; $display("FAIL rst_fields got %h want 0", {bus.mem_sel, bus.mem_addr, bus.mem_data});
    end
  endtask

  task automatic test_regions();
    bit got; logic gr, sok; int d0;
    ack_mode = 1;
    d0 = done_cnt;
    start_load(8'd0);
    wr_byte(25'h0000, 8'hA5); model_byte(25'h0000, 8'hA5);
    wr_byte(25'h3000, 8'h5A); model_byte(25'h3000, 8'h5A);
    wr_byte(25'h4000, 8'h11); model_byte(25'h4000, 8'h11);
    finish_load(got, gr, sok);
    tests++; if (!got) begin fails++; $display("FAIL regions_done got 0 want 1"); end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL regions_pulses got %0d want 1", done_cnt - d0); end
    tests++; if (gr !== !sum_expect()) begin fails++; $display("FAIL regions_game_reset got %b want %b", gr, !sum_expect()); end
    tests++; if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL regions_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL regions_write%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    tests++; if (bus.drop_err !== 1'b0) begin fails++; $display("FAIL regions_drop_err got %b want 0", bus.drop_err); end
  endtask

  task automatic test_drop();
    bit got; logic gr, sok;
    ack_mode = 1;
    start_load(8'd0);
    wr_byte(25'h4400, 8'h33);     model_byte(25'h4400, 8'h33);
    wr_byte(25'h0010, 8'h44);     model_byte(25'h0010, 8'h44);
    wr_byte(25'h1FF_FFFF, 8'h99); model_byte(25'h1FF_FFFF, 8'h99);
    finish_load(got, gr, sok);
    tests++; if (!got) begin fails++; $display("FAIL drop_done got 0 want 1"); end
    tests++; if (bus.drop_err !== 1'b1) begin fails++; $display("FAIL drop_err got %b want 1", bus.drop_err); end
    tests++; if (sok !== sum_expect()) begin fails++; $display("FAIL drop_sum_ok got %b want %b", sok, sum_expect()); end
    tests++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      fails++; $display("FAIL drop_writes got %0d writes, first %h want 1 write %h", obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 26'h0, exp_q[0]);
    end
  endtask

  task automatic test_checksum();
    bit got; logic gr, sok;
    ack_mode = 1;
    start_load(8'd0);
    tests++; if ({bus.drop_err, bus.sum_ok, bus.game_reset} !== 3'b001) begin
      fails++; $display("FAIL cks_start got drop/sum/gr %b want 001", {bus.drop_err, bus.sum_ok, bus.game_reset});
    end
    wr_byte(25'h0000, 8'h80); model_byte(25'h0000, 8'h80);
    wr_byte(25'h0001, 8'h7F); model_byte(25'h0001, 8'h7F);
    finish_load(got, gr, sok);
    tests++; if ({got, sok, gr} !== 3'b110) begin fails++; $display("FAIL cks_match got done/sum/gr %b want 110", {got, sok, gr}); end
    tests++; if (bus.game_reset !== 1'b0) begin fails++; $display("FAIL cks_hold got %b want 0", bus.game_reset); end
    start_load(8'd0);
    wr_byte(25'h3123, 8'h80); model_byte(25'h3123, 8'h80);
    wr_byte(25'h4001, 8'h80); model_byte(25'h4001, 8'h80);
    finish_load(got, gr, sok);
    tests++; if ({got, sok, gr} !== {1'b1, sum_expect(), !sum_expect()}) begin
      fails++; $display("FAIL cks_second got done/sum/gr %b want %b", {got, sok, gr}, {1'b1, sum_expect(), !sum_expect()});
    end
  endtask

  task automatic test_backpressure();
    bit got; logic gr, sok; int n_before = -1;
    logic [24:0] a; logic [7:0] d;
    ack_mode = 0;
    start_load(8'd0);
    for (int i = 0; i < 8; i++) begin
      if (n_before < 0 && bus.ioctl_wait) begin
        n_before = i;
        tick(20);
        tests++; if ({bus.ioctl_wait, bus.mem_req, bus.drop_err} !== 3'b110) begin
          fails++; $display("FAIL bp_stall got wait/req/drop %b want 110", {bus.ioctl_wait, bus.mem_req, bus.drop_err});
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL bp_no_ack_writes got %0d want 0", obs_q.size()); end
        ack_mode = 1;
      end
      a = 25'h3000 + 25'($urandom_range(0, 16'h0FFF));
      d = 8'($urandom_range(0, 255));
      wr_byte(a, d); model_byte(a, d);
    end
    ack_mode = 1;
    tests++; if (n_before != DEPTH) begin fails++; $display("FAIL bp_wait_point got %0d bytes before wait want %0d", n_before, DEPTH); end
    finish_load(got, gr, sok);
    tests++; if (!got || bus.drop_err !== 1'b0) begin fails++; $display("FAIL bp_done got done %b drop %b want 1 0", got, bus.drop_err); end
    tests++; if (obs_q.size() != exp_q.size()) begin
      fails++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_order%0d got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    tests++; if (stab_viol != 0) begin fails++; $display("FAIL bp_stable got %0d changes want 0", stab_viol); end
  endtask

  task automatic test_reset_midload();
    ack_mode = 0;
    start_load(8'd0);
    wr_byte(25'h0100, 8'h01);
    wr_byte(25'h0101, 8'h02);
    wr_byte(25'h0102, 8'h03);
    tick(1);
    tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL mid_req_before got %b want 1", bus.mem_req); end
    #2 reset = 1'b1;
    bus.ioctl_download = 1'b0;
    #1;
    tests++; if ({bus.mem_req, bus.game_reset} !== 2'b01) begin
      fails++; $display("FAIL mid_async got req/gr %b want 01", {bus.mem_req, bus.game_reset});
    end
    @(posedge clk_sys); #1 reset = 1'b0;
    ack_mode = 1;
    obs_q.delete(); exp_q.delete();
    tick(6);
    tests++; if ({bus.mem_req, bus.ioctl_wait, bus.game_reset} !== 3'b001 || obs_q.size() != 0) begin
      fails++; $display("FAIL mid_after got req/wait/gr %b writes %0d want 001 0", {bus.mem_req, bus.ioctl_wait, bus.game_reset}, obs_q.size());
    end
  endtask

  task automatic test_random();
    bit got; logic gr, sok; int n, r, d0;
    logic [24:0] a; logic [7:0] d;
    ack_mode = 2;
    for (int round = 0; round < 4; round++) begin
      d0 = done_cnt;
      start_load(8'd0);
      n = $urandom_range(5, 24);
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 7);
        if (r < 3)      a = 25'($urandom_range(0, 16'h2FFF));
        else if (r < 5) a = 25'h3000 + 25'($urandom_range(0, 16'h0FFF));
        else if (r < 7) a = 25'h4000 + 25'($urandom_range(0, 16'h03FF));
        else            a = 25'h4400 + 25'($urandom_range(0, 20'hFFFFF));
        d = 8'($urandom_range(0, 255));
        wr_byte(a, d); model_byte(a, d);
      end
      finish_load(got, gr, sok);
      tests++; if (!got || done_cnt - d0 != 1) begin fails++; $display("FAIL rnd%0d_done got %b pulses %0d want 1 1", round, got, done_cnt - d0); end
      tests++; if ({bus.drop_err, sok, gr} !== {model_drop, sum_expect(), !sum_expect()}) begin
        fails++; $display("FAIL rnd%0d_status got drop/sum/gr %b want %b", round, {bus.drop_err, sok, gr}, {model_drop, sum_expect(), !sum_expect()});
      end
      tests++; if (obs_q.size() != exp_q.size()) begin
        fails++; $display("FAIL rnd%0d_count got %0d want %0d", round, obs_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          tests++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rnd%0d_write%0d got %h want %h", round, i, obs_q[i], exp_q[i]); end
        end
      end
    end
    d0 = done_cnt;
    start_load(8'h01);
    wr_byte(25'h0000, 8'hEE);
    wr_byte(25'h3000, 8'hDD);
    bus.ioctl_download = 1'b0;
    tick(12);
    bus.ioctl_index = 8'd0;
    tests++; if (obs_q.size() != 0 || done_cnt != d0) begin
      fails++; $display("FAIL rnd_other_index got %0d writes %0d pulses want 0 0", obs_q.size(), done_cnt - d0);
    end
    tests++; if (stab_viol != 0) begin fails++; $display("FAIL rnd_stable got %0d changes want 0", stab_viol); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = 25'd0; bus.ioctl_dout = 8'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    tick(1);
    test_reset();
    test_regions();
    test_drop();
    test_checksum();
    test_backpressure();
    test_reset_midload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
